// File: rtl/mem_rx_pkt_buf_if.sv
// Bundles the byte stream, random read port and frame-descriptor signals of the RX packet buffer.
// The buffer takes the slave view; the MAC/DMA side (or a testbench) takes the master view.
interface mem_rx_pkt_buf_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
);
  localparam int BYTES = DATA_W / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int LEN_W = AW + $clog2(BYTES) + 1;

  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_last;
  logic              s_ready;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              frm_valid;
  logic [AW-1:0]     frm_base;
  logic [LEN_W-1:0]  frm_len;
  logic              frm_done;
  logic [15:0]       drop_cnt;

  modport master (
    output s_valid, s_data, s_last, rd_en, rd_addr, frm_done,
    input  s_ready, rd_data, frm_valid, frm_base, frm_len, drop_cnt
  );

  modport slave (
    input  s_valid, s_data, s_last, rd_en, rd_addr, frm_done,
    output s_ready, rd_data, frm_valid, frm_base, frm_len, drop_cnt
  );
endinterface

// File: rtl/mem_rx_pkt_buf.sv
// RX packet buffer: packs MAC bytes into a byte-enabled ring RAM and publishes one frame descriptor at a time.
// Define RX_ZERO_PAD_EN to write the final word of each frame with unused lanes forced to zero.
module mem_rx_pkt_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic            clk,
  input  logic            rst,
  mem_rx_pkt_buf_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(BYTES);
  localparam int LEN_W = AW + LW + 1;
  localparam int OW    = AW + 1;

`ifdef RX_ZERO_PAD_EN
  localparam bit ZeroPad = 1'b1;
`else
  localparam bit ZeroPad = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FILL, DROP} stateT;

  stateT             stateReg, stateNext;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] stageReg;
  logic [DATA_W-1:0] rdDataReg;
  logic [LW-1:0]     laneReg;
  logic [AW-1:0]     wptrReg;
  logic [AW-1:0]     startReg;
  logic [OW-1:0]     occReg;
  logic [OW-1:0]     frameWordsReg;
  logic [LEN_W-1:0]  byteCntReg;
  logic              rstQ;
  logic              frmValidReg;
  logic [AW-1:0]     frmBaseReg;
  logic [LEN_W-1:0]  frmLenReg;
  logic [OW-1:0]     frmWordsReg;
  logic [15:0]       dropCntReg;

  logic              overflow, dropping, relFrm, sReady, accept, keep;
  logic              wordWr, commit, dropStart, dropEnd;
  logic [DATA_W-1:0] wrData;
  logic [BYTES-1:0]  wrBe;

  // Control: flow control, byte classification and next state.
  always_comb begin
    stateNext = stateReg;
    overflow  = (stateReg == FILL) && (frameWordsReg == OW'(DEPTH));
    dropping  = (stateReg == DROP) || overflow;
    relFrm    = frmValidReg && bus.frm_done;
    sReady    = !rst && !rstQ &&
                (((occReg < OW'(DEPTH)) && !(bus.s_last && frmValidReg && !bus.frm_done)) || dropping);
    accept    = bus.s_valid && sReady;
    keep      = accept && !dropping;
    wordWr    = keep && ((laneReg == LW'(BYTES - 1)) || bus.s_last);
    commit    = keep && bus.s_last;
    dropStart = accept && overflow;
    dropEnd   = accept && dropping && bus.s_last;
    case (stateReg)
      IDLE:    if (keep && !bus.s_last) stateNext = FILL;
      FILL:    if (dropStart) stateNext = bus.s_last ? IDLE : DROP;
               else if (commit) stateNext = IDLE;
      DROP:    if (dropEnd) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Current byte goes straight into its lane; earlier lanes come from the staging register.
  for (genvar gi = 0; gi < BYTES; gi++) begin : gLane
    assign wrData[gi*8 +: 8] = (LW'(gi) == laneReg) ? bus.s_data :
                               (ZeroPad && (LW'(gi) > laneReg)) ? 8'h00 : stageReg[gi*8 +: 8];
    assign wrBe[gi] = ZeroPad || (LW'(gi) <= laneReg);
  end

  always_ff @(posedge clk) begin
    if (wordWr) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wrBe[b]) mem[wptrReg][b*8 +: 8] <= wrData[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdDataReg <= '0;
    else if (bus.rd_en) rdDataReg <= mem[bus.rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg      <= IDLE;
      rstQ          <= 1'b1;
      stageReg      <= '0;
      laneReg       <= '0;
      wptrReg       <= '0;
      startReg      <= '0;
      occReg        <= '0;
      frameWordsReg <= '0;
      byteCntReg    <= '0;
      frmValidReg   <= 1'b0;
      frmBaseReg    <= '0;
      frmLenReg     <= '0;
      frmWordsReg   <= '0;
      dropCntReg    <= '0;
    end else begin
      stateReg <= stateNext;
      rstQ     <= 1'b0;
      if (keep) begin
        stageReg[8*int'(laneReg) +: 8] <= bus.s_data;
        laneReg    <= wordWr ? '0 : laneReg + 1'b1;
        byteCntReg <= commit ? '0 : byteCntReg + 1'b1;
        if (stateReg == IDLE) startReg <= wptrReg;
      end
      // Overflow rewinds to the frame start and forgets every word it wrote.
      if (dropStart) begin
        wptrReg       <= startReg;
        frameWordsReg <= '0;
        byteCntReg    <= '0;
        laneReg       <= '0;
      end else if (wordWr) begin
        wptrReg       <= wptrReg + 1'b1;
        frameWordsReg <= commit ? '0 : frameWordsReg + 1'b1;
      end
      occReg <= occReg + OW'(wordWr) - (relFrm ? frmWordsReg : '0) - (dropStart ? frameWordsReg : '0);
      if (commit) begin
        frmValidReg <= 1'b1;
        frmBaseReg  <= (stateReg == IDLE) ? wptrReg : startReg;
        frmLenReg   <= byteCntReg + 1'b1;
        frmWordsReg <= frameWordsReg + 1'b1;
      end else if (relFrm) begin
        frmValidReg <= 1'b0;
      end
      if (dropEnd && (dropCntReg != 16'hFFFF)) dropCntReg <= dropCntReg + 1'b1;
    end
  end

  assign bus.s_ready   = sReady;
  assign bus.rd_data   = rdDataReg;
  assign bus.frm_valid = frmValidReg;
  assign bus.frm_base  = frmBaseReg;
  assign bus.frm_len   = frmLenReg;
  assign bus.drop_cnt  = dropCntReg;
endmodule
